// File: rtl/cmp_run_monitor_pkg.sv
// Shared types and helpers for the CMP run monitor: state encodings,
// the default halt instruction and the node-select width rule.
package cmp_run_monitor_pkg;

    // Externally visible state, reported on dbg_state.
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_DUMP_RD  = 3'd2,
        ST_DUMP_CAP = 3'd3,
        ST_DUMP_OUT = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        CTL_RUN   = 2'd0,
        CTL_FLUSH = 2'd1,
        CTL_DUMP  = 2'd2,
        CTL_DONE  = 2'd3
    } ctl_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RD   = 2'd1,
        SEQ_CAP  = 2'd2,
        SEQ_OUT  = 2'd3
    } seq_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_run_monitor_dump_seq.sv
// Dump sequencer: walks (addr, node) address-major, issues one DMEM read per
// word, captures the returned data and presents it on a valid/ready port.
module cmp_dump_seq
    import cmp_run_monitor_pkg::*;
#(
    parameter int NUM_NODES  = 4,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 9,
    parameter int DUMP_DEPTH = 128,
    parameter int NODE_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_ready,
    output logic              o_rd_en,
    output logic [NODE_W-1:0] o_node_sel,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_active,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [NODE_W-1:0] o_node,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_finish,
    output seq_e              o_phase
);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_DEPTH - 1);

    seq_e              r_phase;
    seq_e              w_phase_next;
    logic [NODE_W-1:0] r_node;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [NODE_W-1:0] r_out_node;
    logic [ADDR_W-1:0] r_out_index;
    logic              w_hs;
    logic              w_last;

    assign w_hs   = (r_phase == SEQ_OUT) && i_ready;
    // Termination is decided on the last (addr, node) pair, so a full
    // 2**ADDR_W depth never relies on the address counter wrapping.
    assign w_last = (r_node == LAST_NODE) && (r_addr == LAST_ADDR);

    always_comb begin
        w_phase_next = r_phase;
        o_finish     = 1'b0;
        case (r_phase)
            SEQ_IDLE: if (i_start) w_phase_next = SEQ_RD;
            SEQ_RD:   w_phase_next = SEQ_CAP;
            SEQ_CAP:  w_phase_next = SEQ_OUT;
            SEQ_OUT: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_phase_next = SEQ_IDLE;
                        o_finish     = 1'b1;
                    end else begin
                        w_phase_next = SEQ_RD;
                    end
                end
            end
            default:  w_phase_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= SEQ_IDLE;
            r_node      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_out_node  <= '0;
            r_out_index <= '0;
        end else begin
            r_phase <= w_phase_next;
            if (i_start) begin
                r_node <= '0;
                r_addr <= '0;
            end
            if (r_phase == SEQ_CAP) begin
                r_data      <= i_rd_data;
                r_out_node  <= r_node;
                r_out_index <= r_addr;
            end
            if (w_hs && !w_last) begin
                if (r_node == LAST_NODE) begin
                    r_node <= '0;
                    r_addr <= r_addr + ADDR_W'(1);
                end else begin
                    r_node <= r_node + NODE_W'(1);
                end
            end
        end
    end

    assign o_rd_en    = (r_phase == SEQ_RD);
    assign o_node_sel = r_node;
    assign o_addr     = r_addr;
    assign o_active   = (r_phase != SEQ_IDLE);
    assign o_valid    = (r_phase == SEQ_OUT);
    assign o_data     = r_data;
    assign o_node     = r_out_node;
    assign o_index    = r_out_index;
    assign o_phase    = r_phase;

endmodule

// File: rtl/cmp_run_monitor.sv
// CMP run monitor: tracks per-node halts and run cycles, forces completion on
// timeout, waits out a flush interval, then streams every node's DMEM out.
module cmp_run_monitor
    import cmp_run_monitor_pkg::*;
#(
    parameter int                  NUM_NODES    = 4,
    parameter int                  INST_W       = 32,
    parameter int                  DATA_W       = 64,
    parameter int                  ADDR_W       = 9,
    parameter int                  DUMP_DEPTH   = 128,
    parameter int                  FLUSH_CYCLES = 5,
    parameter int                  TIMEOUT      = 3334,
    parameter int                  CNT_W        = 32,
    parameter logic [INST_W-1:0]   HALT_WORD    = INST_W'(HALT_WORD_DEFAULT),
    localparam int                 NODE_W       = sel_width(NUM_NODES)
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_NODES*INST_W-1:0] inst_in,
    output logic                        dump_rd_en,
    output logic [NODE_W-1:0]           dump_node_sel,
    output logic [ADDR_W-1:0]           dump_addr,
    input  logic [DATA_W-1:0]           dump_rd_data,
    output logic                        dump_active,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic [DATA_W-1:0]           dump_data,
    output logic [NODE_W-1:0]           dump_node,
    output logic [ADDR_W-1:0]           dump_index,
    output logic [NUM_NODES-1:0]        halt_mask,
    output logic [CNT_W-1:0]            cycle_count,
    output logic                        timed_out,
    output logic                        done,
    output state_e                      dbg_state
);
    localparam int                FL_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FL_W-1:0]   FL_LAST = FL_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

    ctl_e                 r_ctl;
    ctl_e                 w_ctl_next;
    logic [NUM_NODES-1:0] r_halt_mask;
    logic [NUM_NODES-1:0] w_new_halt;
    logic [CNT_W-1:0]     r_cycle;
    logic                 r_timed_out;
    logic [FL_W-1:0]      r_flush_cnt;
    logic                 w_all_halted;
    logic                 w_timeout_hit;
    logic                 w_start;
    logic                 w_seq_finish;
    seq_e                 w_seq_phase;

    always_comb begin
        w_new_halt = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            w_new_halt[k] = (inst_in[k*INST_W +: INST_W] == HALT_WORD);
        end
    end

    assign w_all_halted  = &(r_halt_mask | w_new_halt);
    assign w_timeout_hit = (r_cycle == TO_LAST);

    always_comb begin
        w_ctl_next = r_ctl;
        w_start    = 1'b0;
        case (r_ctl)
            CTL_RUN: begin
                if (w_all_halted || w_timeout_hit) begin
                    if (FLUSH_CYCLES == 0) begin
                        w_ctl_next = CTL_DUMP;
                        w_start    = 1'b1;
                    end else begin
                        w_ctl_next = CTL_FLUSH;
                    end
                end
            end
            CTL_FLUSH: begin
                if (r_flush_cnt == FL_LAST) begin
                    w_ctl_next = CTL_DUMP;
                    w_start    = 1'b1;
                end
            end
            CTL_DUMP: if (w_seq_finish) w_ctl_next = CTL_DONE;
            CTL_DONE: w_ctl_next = CTL_DONE;
            default:  w_ctl_next = CTL_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ctl       <= CTL_RUN;
            r_halt_mask <= '0;
            r_cycle     <= '0;
            r_timed_out <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_ctl <= w_ctl_next;
            // A halt completing on the timeout cycle takes precedence.
            if (r_ctl == CTL_RUN) begin
                r_halt_mask <= r_halt_mask | w_new_halt;
                if (!w_all_halted) begin
                    if (w_timeout_hit) begin
                        r_timed_out <= 1'b1;
                    end else if (r_cycle != {CNT_W{1'b1}}) begin
                        r_cycle <= r_cycle + CNT_W'(1);
                    end
                end
            end
            if (r_ctl == CTL_FLUSH) r_flush_cnt <= r_flush_cnt + FL_W'(1);
            else                    r_flush_cnt <= '0;
        end
    end

    cmp_dump_seq #(
        .NUM_NODES  (NUM_NODES),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DUMP_DEPTH (DUMP_DEPTH),
        .NODE_W     (NODE_W)
    ) u_dump_seq (
        .clk        (CLK),
        .rst        (RESET),
        .i_start    (w_start),
        .i_rd_data  (dump_rd_data),
        .i_ready    (dump_ready),
        .o_rd_en    (dump_rd_en),
        .o_node_sel (dump_node_sel),
        .o_addr     (dump_addr),
        .o_active   (dump_active),
        .o_valid    (dump_valid),
        .o_data     (dump_data),
        .o_node     (dump_node),
        .o_index    (dump_index),
        .o_finish   (w_seq_finish),
        .o_phase    (w_seq_phase)
    );

    always_comb begin
        dbg_state = ST_RUN;
        case (r_ctl)
            CTL_RUN:   dbg_state = ST_RUN;
            CTL_FLUSH: dbg_state = ST_FLUSH;
            CTL_DONE:  dbg_state = ST_DONE;
            CTL_DUMP: begin
                case (w_seq_phase)
                    SEQ_CAP: dbg_state = ST_DUMP_CAP;
                    SEQ_OUT: dbg_state = ST_DUMP_OUT;
                    default: dbg_state = ST_DUMP_RD;
                endcase
            end
            default:   dbg_state = ST_RUN;
        endcase
    end

    assign halt_mask   = r_halt_mask;
    assign cycle_count = r_cycle;
    assign timed_out   = r_timed_out;
    assign done        = (r_ctl == CTL_DONE);

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Directed bench for cmp_run_monitor: instance a (N=4, DEPTH=4, FLUSH=2) and
// instance b (FLUSH=0, DEPTH=2**ADDR_W=8), sharing clock, reset and inst_in.
module tb_cmp_run_monitor;
    import cmp_run_monitor_pkg::*;

    localparam logic [31:0] NZ = 32'h1300_0013;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [127:0] inst_in = {4{NZ}};
    logic         a_ready = 1'b0;
    logic         b_ready = 1'b0;

    logic        a_rd_en, a_active, a_valid, a_timed, a_done;
    logic [1:0]  a_node_sel, a_node;
    logic [8:0]  a_addr, a_index;
    logic [63:0] a_rd_data = '0, a_data;
    logic [3:0]  a_mask;
    logic [31:0] a_count;
    state_e      a_state;

    logic        b_rd_en, b_active, b_valid, b_timed, b_done;
    logic [1:0]  b_node_sel, b_node;
    logic [2:0]  b_addr, b_index;
    logic [63:0] b_rd_data = '0, b_data;
    logic [3:0]  b_mask;
    logic [31:0] b_count;
    state_e      b_state;

    int n_assert = 0;
    int n_fail   = 0;
    logic [87:0] exp_q[$];

    always #5 CLK = ~CLK;

    cmp_run_monitor #(.NUM_NODES(4), .ADDR_W(9), .DUMP_DEPTH(4), .FLUSH_CYCLES(2), .TIMEOUT(20)) u_a (
        .CLK(CLK), .RESET(RESET), .inst_in(inst_in),
        .dump_rd_en(a_rd_en), .dump_node_sel(a_node_sel), .dump_addr(a_addr),
        .dump_rd_data(a_rd_data), .dump_active(a_active), .dump_valid(a_valid),
        .dump_ready(a_ready), .dump_data(a_data), .dump_node(a_node), .dump_index(a_index),
        .halt_mask(a_mask), .cycle_count(a_count), .timed_out(a_timed), .done(a_done),
        .dbg_state(a_state)
    );

    cmp_run_monitor #(.NUM_NODES(4), .ADDR_W(3), .DUMP_DEPTH(8), .FLUSH_CYCLES(0), .TIMEOUT(20)) u_b (
        .CLK(CLK), .RESET(RESET), .inst_in(inst_in),
        .dump_rd_en(b_rd_en), .dump_node_sel(b_node_sel), .dump_addr(b_addr),
        .dump_rd_data(b_rd_data), .dump_active(b_active), .dump_valid(b_valid),
        .dump_ready(b_ready), .dump_data(b_data), .dump_node(b_node), .dump_index(b_index),
        .halt_mask(b_mask), .cycle_count(b_count), .timed_out(b_timed), .done(b_done),
        .dbg_state(b_state)
    );

    function automatic logic [63:0] mem_word(input int n, input int a);
        return {24'hC0FFEE, 8'(n), 16'h0, 16'(a)};
    endfunction

    function automatic logic [87:0] pk(input int n, input int a, input logic [63:0] d);
        return {8'(n), 16'(a), d};
    endfunction

    function automatic logic [127:0] mk_inst(input logic [3:0] halt);
        logic [127:0] v;
        for (int k = 0; k < 4; k++) v[k*32 +: 32] = halt[k] ? 32'h0 : NZ;
        return v;
    endfunction

    // DMEM models: data returned one cycle after the read strobe.
    always @(posedge CLK) begin
        if (a_rd_en) a_rd_data <= mem_word(int'(a_node_sel), int'(a_addr));
        if (b_rd_en) b_rd_data <= mem_word(int'(b_node_sel), int'(b_addr));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int depth);
        exp_q.delete();
        for (int a = 0; a < depth; a++)
            for (int n = 0; n < 4; n++)
                exp_q.push_back(pk(n, a, mem_word(n, a)));
    endtask

    task automatic do_reset();
        RESET   = 1'b1;
        inst_in = {4{NZ}};
        a_ready = 1'b0;
        b_ready = 1'b0;
        tick();
        tick();
        chk("reset_a_outputs", {a_rd_en, a_node_sel, a_addr, a_active, a_valid, a_data, a_node,
            a_index, a_mask, a_count, a_timed, a_done, a_state}, '0);
        chk("reset_b_outputs", {b_rd_en, b_node_sel, b_addr, b_active, b_valid, b_data, b_node,
            b_index, b_mask, b_count, b_timed, b_done, b_state}, '0);
        RESET = 1'b0;
    endtask

    // Consume dump words from instance a (sel=0) or b (sel=1); stop early
    // once stop_after handshakes are pending (0 = never).
    task automatic drain(input bit sel, input int n_words, input bit rand_rdy, input int stop_after);
        int got = 0;
        int guard = 0;
        bit v, r, prev_stall;
        logic [87:0] cur, held, e;
        prev_stall = 1'b0;
        held = '0;
        while (got < n_words && guard < 4000) begin
            tick();
            guard++;
            v   = sel ? b_valid : a_valid;
            cur = sel ? pk(int'(b_node), int'(b_index), b_data) : pk(int'(a_node), int'(a_index), a_data);
            if (prev_stall) chk("stable_under_stall", {v, cur}, {1'b1, held});
            r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v && r) begin
                chk("queue_not_empty", exp_q.size() != 0, 1);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                chk("word_node", cur[87:80], e[87:80]);
                chk("word_index", cur[79:64], e[79:64]);
                chk("word_data", cur[63:0], e[63:0]);
                got++;
            end
            prev_stall = v && !r;
            held = cur;
            if (sel) b_ready = r; else a_ready = r;
            if (stop_after > 0 && got == stop_after) break;
        end
        chk("drain_in_budget", guard < 4000, 1);
    endtask

    task automatic wait_done(input bit sel);
        int g = 0;
        tick();
        while (!(sel ? b_done : a_done) && g < 50) begin
            tick();
            g++;
        end
        a_ready = 1'b0;
        b_ready = 1'b0;
        chk("done_set", sel ? b_done : a_done, 1);
        chk("active_clear", sel ? b_active : a_active, 0);
        chk("valid_clear", sel ? b_valid : a_valid, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        // Staggered halts at RUN cycles 3,7,5,9 with ready held high.
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            inst_in = mk_inst({k == 9, k == 5, k == 7, k == 3});
            tick();
            if (k == 3) begin
                chk("t1_mask_k3", a_mask, 4'h1);
                chk("t1_count_k3", a_count, 4);
            end
            if (k == 7) chk("t1_mask_k7", a_mask, 4'h7);
        end
        inst_in = {4{NZ}};
        chk("t1_mask", a_mask, 4'hF);
        chk("t1_count", a_count, 9);
        chk("t1_timed", a_timed, 0);
        chk("t1_state_flush", a_state, ST_FLUSH);
        tick();
        chk("t1_rd_en_flush", a_rd_en, 0);
        tick();
        chk("t1_rd_en_first", {a_rd_en, a_active, a_node_sel, a_addr}, {1'b1, 1'b1, 2'd0, 9'd0});
        fill(4);
        drain(1'b0, 16, 1'b0, 0);
        wait_done(1'b0);
        chk("t1_hold_after_done", {a_mask, a_count, a_timed}, {4'hF, 32'd9, 1'b0});

        // Node 2 never halts: timeout, then random back-pressure on the dump.
        do_reset();
        for (int k = 0; k <= 19; k++) begin
            inst_in = mk_inst((k == 2) ? 4'b1011 : 4'b0000);
            tick();
            if (k == 2) chk("t2_mask_early", a_mask, 4'hB);
            if (k == 18) chk("t2_pre_timeout", {a_timed, a_count}, {1'b0, 32'd19});
        end
        chk("t2_timed", a_timed, 1);
        chk("t2_count", a_count, 19);
        chk("t2_mask", a_mask, 4'hB);
        inst_in = mk_inst(4'hF);
        tick();
        chk("t2_flush_ignores_inst", a_mask, 4'hB);
        inst_in = {4{NZ}};
        fill(4);
        drain(1'b0, 16, 1'b1, 0);
        wait_done(1'b0);
        chk("t2_timed_hold", a_timed, 1);

        // Reset in the middle of the dump, then a clean rerun.
        do_reset();
        inst_in = mk_inst(4'hF);
        tick();
        inst_in = {4{NZ}};
        chk("t5_count", a_count, 0);
        fill(4);
        drain(1'b0, 16, 1'b0, 6);
        RESET = 1'b1;
        tick();
        chk("t5_abort_outputs", {a_rd_en, a_node_sel, a_addr, a_active, a_valid, a_data, a_node,
            a_index, a_mask, a_count, a_timed, a_done, a_state}, '0);
        RESET = 1'b0;
        a_ready = 1'b0;
        for (int k = 0; k <= 2; k++) begin
            inst_in = mk_inst((k == 2) ? 4'hF : 4'h0);
            tick();
        end
        inst_in = {4{NZ}};
        chk("t5_rerun_count", a_count, 2);
        fill(4);
        drain(1'b0, 16, 1'b1, 0);
        wait_done(1'b0);

        // All halts land on the timeout cycle; b also covers FLUSH=0 and full depth.
        do_reset();
        for (int k = 0; k <= 19; k++) begin
            inst_in = mk_inst((k == 19) ? 4'hF : 4'h0);
            tick();
        end
        inst_in = {4{NZ}};
        chk("t6_a_halt_wins", {a_timed, a_count, a_mask}, {1'b0, 32'd19, 4'hF});
        chk("t6_b_halt_wins", {b_timed, b_count, b_mask}, {1'b0, 32'd19, 4'hF});
        chk("t6_b_no_flush", {b_rd_en, b_active, b_state}, {1'b1, 1'b1, ST_DUMP_RD});
        fill(8);
        drain(1'b1, 32, 1'b1, 0);
        wait_done(1'b1);
        chk("t6_b_state_done", b_state, ST_DONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
